secp256k1_point_check: RTL and testbench

SECP256K1_POINT_CHECK -- requirements
Module: secp256k1_point_check

---
 rtl/secp256k1_point_check_if.sv | 26 ++
 rtl/secp256k1_point_check.sv | 129 ++++++++++++
 tb/tb_secp256k1_point_check.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/secp256k1_point_check_if.sv
// Job/result handshake bundle for the secp256k1 on-curve checker.
// The master drives jobs and result acceptance; the slave is the checker.
interface secp256k1_point_check_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] x1;
    logic [255:0] y1;
    logic [255:0] k;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] x_out;
    logic [255:0] y_out;
    logic [255:0] k_out;
    logic         on_curve;
    logic         busy;

    modport master (
        output in_valid, x1, y1, k, out_ready,
        input  in_ready, out_valid, x_out, y_out, k_out, on_curve, busy
    );

    modport slave (
        input  in_valid, x1, y1, k, out_ready,
        output in_ready, out_valid, x_out, y_out, k_out, on_curve, busy
    );
endinterface

// File: rtl/secp256k1_point_check.sv
// Checks that (x1, y1) lies on y^2 = x^3 + b mod p using three bit-serial
// MSB-first modular multiplies; k is carried through for the point multiplier.
module secp256k1_point_check #(
    parameter logic [255:0] CURVE_B = 256'd7
) (
    input  logic                          clk,
    input  logic                          reset,
    secp256k1_point_check_if.slave        bus
);

    localparam logic [256:0] P =
        {1'b0, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F};

    typedef enum logic [2:0] {
        IDLE, RANGE, MUL_X2, MUL_X3, MUL_Y2, CMP, OUT
    } state_t;

    state_t       r_state, w_next;
    logic [255:0] r_x, r_y, r_k, r_x2, r_x3, r_acc;
    logic [7:0]   r_bit;
    logic         r_on_curve;

    logic         w_accept, w_in_range, w_last, w_mul_bit;
    logic [255:0] w_mul_a, w_mul_b;
    logic [256:0] w_dbl, w_add, w_sum;
    logic [255:0] w_dbl_red, w_add_red, w_sum_red, w_acc_next;

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_in_range = ({1'b0, r_x} < P) && ({1'b0, r_y} < P);
    assign w_last     = (r_bit == 8'd0);

    // Operand selection: x*x, then x2*x, then y*y.
    always_comb begin
        // NOTE: defaults first so every path assigns both, otherwise a latch is inferred.
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            MUL_X2:  begin w_mul_a = r_x;  w_mul_b = r_x; end
            MUL_X3:  begin w_mul_a = r_x2; w_mul_b = r_x; end
            MUL_Y2:  begin w_mul_a = r_y;  w_mul_b = r_y; end
            default: ;
        endcase
    end

    // acc stays in [0, p-1]: 2*acc and acc+a are both < 2p, so one subtraction suffices.
    assign w_mul_bit  = w_mul_b[r_bit];
    assign w_dbl      = {r_acc, 1'b0};
    assign w_dbl_red  = (w_dbl >= P) ? 256'(w_dbl - P) : 256'(w_dbl);
    assign w_add      = {1'b0, w_dbl_red} + {1'b0, w_mul_a};
    assign w_add_red  = (w_add >= P) ? 256'(w_add - P) : 256'(w_add);
    assign w_acc_next = w_mul_bit ? w_add_red : w_dbl_red;

    // CURVE_B is assumed to be below p.
    assign w_sum      = {1'b0, r_x3} + {1'b0, CURVE_B};
    assign w_sum_red  = (w_sum >= P) ? 256'(w_sum - P) : 256'(w_sum);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RANGE;
            RANGE:   w_next = w_in_range ? MUL_X2 : OUT;
            MUL_X2:  if (w_last) w_next = MUL_X3;
            MUL_X3:  if (w_last) w_next = MUL_Y2;
            MUL_Y2:  if (w_last) w_next = CMP;
            CMP:     w_next = OUT;
            OUT:     if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_k        <= '0;
            r_x2       <= '0;
            r_x3       <= '0;
            r_acc      <= '0;
            r_bit      <= '0;
            r_on_curve <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x <= bus.x1;
                        r_y <= bus.y1;
                        r_k <= bus.k;
                    end
                end
                RANGE: begin
                    r_on_curve <= 1'b0;
                    r_acc      <= '0;
                    r_bit      <= 8'd255;
                end
                MUL_X2, MUL_X3, MUL_Y2: begin
                    r_bit <= r_bit - 8'd1;
                    if (!w_last) begin
                        r_acc <= w_acc_next;
                    end else if (r_state == MUL_X2) begin
                        r_x2  <= w_acc_next;
                        r_acc <= '0;
                    end else if (r_state == MUL_X3) begin
                        r_x3  <= w_acc_next;
                        r_acc <= '0;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                end
                CMP:     r_on_curve <= (w_sum_red == r_acc);
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = (r_state == OUT);
    assign bus.x_out     = r_x;
    assign bus.y_out     = r_y;
    assign bus.k_out     = r_k;
    assign bus.on_curve  = r_on_curve;

endmodule

// File: tb/tb_secp256k1_point_check.sv
// Scoreboard bench: drivers push expected results, a negedge monitor pops
// and compares each time out_valid rises.
module tb_secp256k1_point_check;

    localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] GY1 = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B9;
    localparam logic [255:0] ONES = {256{1'b1}};
    localparam int LAT_FULL = 770;
    localparam int LAT_RANGE = 1;

    typedef struct {
        logic         on_curve;
        logic [255:0] x;
        logic [255:0] y;
        logic [255:0] k;
        int           lat;
        int           e0;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    secp256k1_point_check_if bus();

    secp256k1_point_check #(.CURVE_B(256'd7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one comparison set per result, taken when out_valid first rises.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && !prev_ov) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: out_valid rose at cycle %0d with no job pending", cyc);
            end else begin
                m_e = sb.pop_front();
                check("on_curve", 256'(bus.on_curve), 256'(m_e.on_curve));
                check("x_out",    bus.x_out, m_e.x);
                check("y_out",    bus.y_out, m_e.y);
                check("k_out",    bus.k_out, m_e.k);
                check("latency",  256'(cyc - m_e.e0), 256'(m_e.lat));
            end
        end
        prev_ov = (bus.out_valid === 1'b1);
    end

    task automatic push_exp(input logic [255:0] x, input logic [255:0] y, input logic [255:0] k,
                            input logic on, input int lat, input int e0);
        exp_t e;
        e.x = x; e.y = y; e.k = k; e.on_curve = on; e.lat = lat; e.e0 = e0;
        sb.push_back(e);
    endtask

    // Present a job, wait (bounded) for acceptance, optionally log its expected result.
    task automatic send(input logic [255:0] x, input logic [255:0] y, input logic [255:0] k,
                        input logic on, input int lat, input bit expect_result, output int e0);
        int waited = 0;
        e0 = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x1 = x;
        bus.y1 = y;
        bus.k  = k;
        while (bus.in_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            check("accept_timeout", 256'(bus.in_ready), 256'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        if (expect_result) push_exp(x, y, k, on, lat, e0);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (!(sb.size() == 0 && bus.busy === 1'b0) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            check("done_timeout", 256'(sb.size()), 256'd0);
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int waited;

        // Reset with a job presented: nothing may be accepted.
        bus.in_valid  = 1'b1;
        bus.x1        = GX;
        bus.y1        = GY;
        bus.k         = 256'd1;
        bus.out_ready = 1'b1;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  256'(bus.in_ready),  256'd1);
        check("rst_busy",      256'(bus.busy),      256'd0);
        check("rst_out_valid", 256'(bus.out_valid), 256'd0);
        check("rst_on_curve",  256'(bus.on_curve),  256'd0);
        check("rst_x_out",     bus.x_out, 256'd0);
        check("rst_k_out",     bus.k_out, 256'd0);
        bus.in_valid = 1'b0;
        reset = 1'b1;

        // Generator point, then a perturbed y, range failures and the zero point.
        send(GX, GY,  256'd1, 1'b1, LAT_FULL,  1'b1, e0); wait_idle();
        send(GX, GY1, 256'd2, 1'b0, LAT_FULL,  1'b1, e0); wait_idle();
        send(P,  GY,  256'd5, 1'b0, LAT_RANGE, 1'b1, e0); wait_idle();
        send(GX, P,   256'd6, 1'b0, LAT_RANGE, 1'b1, e0); wait_idle();
        send('0, '0,  ONES,   1'b0, LAT_FULL,  1'b1, e0); wait_idle();

        // Backpressure: hold the result, garbage on the input side must be ignored.
        bus.out_ready = 1'b0;
        send(GX, GY, 256'd2, 1'b1, LAT_FULL, 1'b1, e0);
        bus.in_valid = 1'b1;
        bus.x1 = '0;
        bus.y1 = '0;
        bus.k  = '0;
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("stall_reached_out", 256'(bus.out_valid), 256'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_out_valid", 256'(bus.out_valid), 256'd1);
            check("stall_in_ready",  256'(bus.in_ready),  256'd0);
            check("stall_x_out",     bus.x_out, GX);
            check("stall_k_out",     bus.k_out, 256'd2);
            check("stall_on_curve",  256'(bus.on_curve), 256'd1);
        end
        bus.x1 = GX;
        bus.y1 = GY;
        bus.k  = 256'd3;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_busy",      256'(bus.busy),      256'd0);
        check("release_in_ready",  256'(bus.in_ready),  256'd1);
        check("release_out_valid", 256'(bus.out_valid), 256'd0);
        @(negedge clk);
        check("next_accept_busy", 256'(bus.busy), 256'd1);
        push_exp(GX, GY, 256'd3, 1'b1, LAT_FULL, cyc);
        bus.in_valid = 1'b0;
        wait_idle();

        // Abort during MUL_X3 with a one-cycle reset; no result may follow.
        send(GX, GY, 256'd4, 1'b1, LAT_FULL, 1'b0, e0);
        while (cyc < e0 + 300) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_out_valid", 256'(bus.out_valid), 256'd0);
        check("abort_in_ready",  256'(bus.in_ready),  256'd1);
        check("abort_busy",      256'(bus.busy),      256'd0);
        check("abort_x_out",     bus.x_out, 256'd0);
        repeat (800) @(negedge clk);
        send(GX, GY, 256'd9, 1'b1, LAT_FULL, 1'b1, e0);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
